// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide engine.
//   md_op_e    : operation codes carried on the 2-bit op port.
//   md_state_e : engine FSM states.
//   RESET_ENABLE, WRITE_ENABLE, WRITE_DISABLE : active levels, matching the
//              existing stage defines.
//   md_is_div / md_is_signed : op classification helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction applied to the unsigned-magnitude results of
// the multiply/divide engine (used by both the iterative and fast paths).
// Ports:
//   sign_a, sign_b : operand signs latched at accept (0 for unsigned ops)
//   op             : latched operation
//   hi_raw, lo_raw : magnitude result (product halves, or remainder/quotient)
//   hi, lo         : signed-corrected result
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             sign_a,
    input  logic             sign_b,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] hi_raw,
    input  logic [WIDTH-1:0] lo_raw,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        prod     = {hi_raw, lo_raw};
        prod_neg = -prod;
        hi       = hi_raw;
        lo       = lo_raw;
        case (op)
            MD_MULT: begin
                // The product is negated as one double-width value so the
                // borrow propagates from LO into HI.
                if (sign_a ^ sign_b) begin
                    hi = prod_neg[2*WIDTH-1:WIDTH];
                    lo = prod_neg[WIDTH-1:0];
                end
            end
            MD_DIV: begin
                if (sign_a ^ sign_b) lo = -lo_raw;
                // Remainder follows the dividend's sign.
                if (sign_a) hi = -hi_raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide engine for the execute stage (MULT, MULTU, DIV,
// DIVU) producing HI/LO results. One result bit per cycle in RUN, then one
// FIX cycle for sign correction, then a one-cycle DONE pulse.
// Optional feature: define MULDIV_FAST_MUL_EN to use a single-cycle
// WIDTH x WIDTH multiplier for MULT/MULTU (IDLE -> FIX -> DONE).
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   start, op         : request a new operation (accepted in IDLE or DONE)
//   operand_a/b       : multiplicand/dividend, multiplier/divisor
//   cancel            : flush; abort any operation in flight
//   stall_request     : hold the pipeline (combinational)
//   busy              : operation in flight (RUN or FIX), registered
//   done              : one-cycle result-valid pulse
//   hilo_write_enable : equals done
//   hi_o, lo_o        : product high/low, or remainder/quotient
// Handshake: a request is taken on any cycle where start=1, cancel=0 and the
// engine is IDLE or DONE; operands are sampled only on that cycle. hi_o/lo_o
// are valid while done=1 and hold until the next FIX.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    output logic             stall_request,
    output logic             busy,
    output logic             done,
    output logic             hilo_write_enable,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] count;
    md_op_e           op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    // {acc_q, work_q}: {acc, multiplier} for multiply, {rem, quotient} for divide
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] work_q;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0] opnd_q;

    md_op_e           op_in;
    logic             in_div;
    logic             in_signed;
    logic             neg_a;
    logic             neg_b;
    logic             div_zero;
    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] mul_work_next;
    logic [WIDTH:0]   div_rem_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_acc_next;
    logic [WIDTH-1:0] div_work_next;

    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // Request decode
    always_comb begin
        op_in     = md_op_e'(op);
        in_div    = md_is_div(op_in);
        in_signed = md_is_signed(op_in);
        neg_a     = in_signed && operand_a[WIDTH-1];
        neg_b     = in_signed && operand_b[WIDTH-1];
        mag_a     = neg_a ? -operand_a : operand_a;
        mag_b     = neg_b ? -operand_b : operand_b;
        div_zero  = in_div && (operand_b == '0);
        accept    = start && !cancel && ((state == IDLE) || (state == DONE));
    end

    // One iteration step of each algorithm
    always_comb begin
        // Shift-add: add multiplicand when multiplier LSB is set, then shift
        // the whole {carry, acc, multiplier} right by one.
        mul_sum       = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_next  = mul_sum[WIDTH:1];
        mul_work_next = {mul_sum[0], work_q[WIDTH-1:1]};
        // Restoring divide: the shifted remainder is < 2*divisor, so bit WIDTH
        // of the difference is a reliable borrow flag.
        div_rem_sh    = {acc_q, work_q[WIDTH-1]};
        div_diff      = div_rem_sh - {1'b0, opnd_q};
        div_ok        = !div_diff[WIDTH];
        div_acc_next  = div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
        div_work_next = {work_q[WIDTH-2:0], div_ok};
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (cancel) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (div_zero) begin
                            state_next = FIX;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!in_div) begin
                            state_next = FIX;
`endif
                        end else begin
                            state_next = RUN;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                RUN:     if (count == CNT_W'(1)) state_next = FIX;
                FIX:     state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            op_q     <= MD_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN) || (state_next == FIX);
            if (accept) begin
                op_q     <= op_in;
                count    <= CNT_W'(WIDTH);
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                acc_q    <= '0;
                if (in_div) begin
                    if (div_zero) begin
                        // Preload the fixed divide-by-zero result; cleared
                        // signs make FIX pass it through untouched.
                        sign_a_q <= 1'b0;
                        sign_b_q <= 1'b0;
                        acc_q    <= operand_a;
                        work_q   <= '1;
                    end else begin
                        work_q <= mag_a;
                        opnd_q <= mag_b;
                    end
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    acc_q  <= fast_prod[2*WIDTH-1:WIDTH];
                    work_q <= fast_prod[WIDTH-1:0];
`else
                    work_q <= mag_b;
                    opnd_q <= mag_a;
`endif
                end
            end else if ((state == RUN) && !cancel) begin
                count <= count - CNT_W'(1);
                if (md_is_div(op_q)) begin
                    acc_q  <= div_acc_next;
                    work_q <= div_work_next;
                end else begin
                    acc_q  <= mul_acc_next;
                    work_q <= mul_work_next;
                end
            end
            // A cancelled FIX leaves the previous results in place.
            if ((state == FIX) && !cancel) begin
                hi_o <= fix_hi;
                lo_o <= fix_lo;
            end
        end
    end

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .op     (op_q),
        .hi_raw (acc_q),
        .lo_raw (work_q),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    // Outputs
    always_comb begin
        done              = (state == DONE) && !cancel;
        hilo_write_enable = done ? WRITE_ENABLE : WRITE_DISABLE;
        stall_request     = (start && (state == IDLE)) || (state == RUN) ||
                            (state == FIX) || (start && (state == DONE));
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (WIDTH=32, default build).
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         cancel;
    logic         stall_request;
    logic         busy;
    logic         done;
    logic         hilo_write_enable;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int vectors     = 0;
    int miscompares = 0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op                (op),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .cancel            (cancel),
        .stall_request     (stall_request),
        .busy              (busy),
        .done              (done),
        .hilo_write_enable (hilo_write_enable),
        .hi_o              (hi_o),
        .lo_o              (lo_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request in the current cycle (called just after a rising edge).
    task automatic issue(input logic [1:0] op_v, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op        = op_v;
        operand_a = a;
        operand_b = b;
    endtask

    // Follow an accepted request until done; first_cycle is the cycle index
    // (relative to accept) of the current cycle. Returns at the falling edge
    // of the done cycle. Operands are scrambled after accept.
    task automatic wait_done(input string tag, input int first_cycle, input int exp_lat,
                             input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc;
        bit seen;
        bit stall_ok;
        bit busy_ok;
        cyc      = first_cycle;
        seen     = 1'b0;
        stall_ok = 1'b1;
        busy_ok  = 1'b1;
        while (!seen && cyc <= exp_lat + 8) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!stall_request) stall_ok = 1'b0;
                if ((cyc == 0) == busy) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                start     = 1'b0;
                op        = 2'($urandom_range(0, 3));
                operand_a = $urandom;
                operand_b = $urandom;
                cyc++;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_stall_while_busy"}, 32'(stall_ok), 32'd1);
        check_eq({tag, "_busy_profile"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_hilo_we"}, 32'(hilo_write_enable), 32'd1);
        check_eq({tag, "_stall_at_done"}, 32'(stall_request), 32'd0);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_hi"}, hi_o, exp_hi);
        check_eq({tag, "_lo"}, lo_o, exp_lo);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        issue(op_v, a, b);
        wait_done(tag, 0, exp_lat, exp_hi, exp_lo);
        @(posedge clk);
        #1;
    endtask

    // Count done pulses over a window of cycles.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done || hilo_write_enable) pulses++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] hold_hi;
    logic [W-1:0] hold_lo;
    int           pulses;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = MD_MULT;
        operand_a = '0;
        operand_b = '0;
        cancel    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_hilo_we", 32'(hilo_write_enable), 32'd0);
        check_eq("rst_stall", 32'(stall_request), 32'd0);
        check_eq("rst_hi", hi_o, 32'h0);
        check_eq("rst_lo", lo_o, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Main function
        run_op("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg4xneg6", MD_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 34, 32'h0, 32'h0000_0018);
        run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_neg2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
        run_op("div_by_zero", MD_DIV, 32'h0000_1234, 32'h0, 2, 32'h0000_1234, 32'hFFFF_FFFF);

        // Results hold after DONE
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("hold_hi", hi_o, 32'h0000_1234);
        check_eq("hold_lo", lo_o, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

        // cancel together with start is not accepted
        issue(MD_DIVU, 32'd50, 32'd5);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check_eq("cancel_start_busy", 32'(busy), 32'd0);
        check_eq("cancel_start_stall", 32'(stall_request), 32'd0);
        @(posedge clk);
        #1;

        // Cancel mid-divide at cycle 10
        hold_hi = 32'h0000_1234;
        hold_lo = 32'hFFFF_FFFF;
        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        check_eq("cancel_done_same_cycle", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check_eq("cancel_idle_busy", 32'(busy), 32'd0);
        check_eq("cancel_idle_stall", 32'(stall_request), 32'd0);
        count_done(40, pulses);
        check_eq("cancel_no_done", pulses, 32'd0);
        check_eq("cancel_hi_kept", hi_o, hold_hi);
        check_eq("cancel_lo_kept", lo_o, hold_lo);
        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 34, 32'h0, 32'd42);

        // Reset at cycle 5 of a MULT
        issue(MD_MULT, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_hilo_we", 32'(hilo_write_enable), 32'd0);
        check_eq("midrst_stall", 32'(stall_request), 32'd0);
        check_eq("midrst_hi", hi_o, 32'h0);
        check_eq("midrst_lo", lo_o, 32'h0);
        reset = 1'b0;
        count_done(40, pulses);
        check_eq("midrst_no_done", pulses, 32'd0);

        // Back-to-back: new start accepted in the DONE cycle
        issue(MD_MULTU, 32'd3, 32'd4);
        wait_done("b2b_first", 0, 34, 32'h0, 32'd12);
        issue(MD_DIVU, 32'd81, 32'd9);
        #1;
        check_eq("b2b_stall_in_done", 32'(stall_request), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", 1, 34, 32'h0, 32'd9);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
